// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word data memory behind a req/ack handshake.
// A request is captured in IDLE, held for a fixed latency and then completed
// with a single-cycle ack. Misaligned or out-of-range accesses still get an
// ack, but with err_o set; they never touch the array.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // The counter only has to hold LATENCY-2 (loaded on entry to WAIT).
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          cap_we;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [31:0]   mem [DEPTH];

    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          enter_resp;

    // The access being completed: with LATENCY=1 RESP is entered straight
    // from IDLE, so the live inputs are used instead of the captured copy.
    always_comb begin
        acc_we     = (state == IDLE) ? we_i    : cap_we;
        acc_addr   = (state == IDLE) ? addr_i  : cap_addr;
        acc_wdata  = (state == IDLE) ? wdata_i : cap_wdata;
        acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
        acc_idx    = acc_addr[AW+1:2];
        enter_resp = ((state == IDLE) && req_i && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == '0));
    end

    // Control FSM plus read/err result registers, updated on RESP entry only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            if (enter_resp) begin
                err_o   <= acc_err;
                rdata_o <= (acc_we || acc_err) ? 32'h0 : mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request capture; only meaningful while an access is in flight.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && req_i) begin
            cap_we    <= we_i;
            cap_addr  <= addr_i;
            cap_wdata <= wdata_i;
        end
    end

    // Array write commits at the RESP-entry edge; reset drops it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp && acc_we && !acc_err)
            mem[acc_idx] <= acc_wdata;
    end

    assign ready_o = (state == IDLE);
    assign ack_o   = (state == RESP);
    assign stall_o = req_i & ~ack_o;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances at LATENCY 2/1/3/7 share a clock,
// each checked against a reference word array and an expected-response queue.
module tb_dmem_responder;

    localparam int DEP = 16;
    localparam int ND  = 4;

    function automatic int lat_of(input int g);
        case (g)
            0: return 2;
            1: return 1;
            2: return 3;
            default: return 7;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst   [ND];
    logic        req   [ND];
    logic        we    [ND];
    logic [31:0] addr  [ND];
    logic [31:0] wdata [ND];
    logic        ready [ND];
    logic        ack   [ND];
    logic [31:0] rdata [ND];
    logic        err   [ND];
    logic        stall [ND];

    logic [31:0] mdl [ND][DEP];
    logic [32:0] sb_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dmem_responder #(.DEPTH(DEP), .LATENCY(lat_of(g))) u_dut (
            .clk_i   (clk),
            .rst_i   (rst[g]),
            .req_i   (req[g]),
            .we_i    (we[g]),
            .addr_i  (addr[g]),
            .wdata_i (wdata[g]),
            .ready_o (ready[g]),
            .ack_o   (ack[g]),
            .rdata_o (rdata[g]),
            .err_o   (err[g]),
            .stall_o (stall[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on instance d, starting just after a rising edge (cycle c0).
    // keep leaves req_i high after the ack; toggle scrambles req/addr in WAIT.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input bit keep, input bit toggle);
        logic        e;
        logic [31:0] ex;
        logic [32:0] pr;
        int          n;
        e  = (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEP));
        ex = 32'h0;
        if (!e) begin
            if (w) mdl[d][int'(a[31:2])] = wd;
            else   ex = mdl[d][int'(a[31:2])];
        end
        sb_q.push_back({e, ex});
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (ack[d] || n > 40) break;
            if (n == 0) chk("ready_c0", 32'(ready[d]), 32'd1);
            else        chk("ready_wait", 32'(ready[d]), 32'd0);
            if (req[d]) chk("stall_busy", 32'(stall[d]), 32'd1);
            n++;
            tick();
            if (toggle) begin
                req[d]  = 1'($urandom_range(0, 1));
                addr[d] = $urandom;
                we[d]   = ~w;
            end
        end
        chk("ack_latency", 32'(n), 32'(lat_of(d)));
        pr = sb_q.pop_front();
        if (ack[d]) begin
            chk("ack_ready", 32'(ready[d]), 32'd0);
            if (req[d]) chk("ack_stall", 32'(stall[d]), 32'd0);
            chk("rdata", rdata[d], pr[31:0]);
            chk("err", 32'(err[d]), 32'(pr[32]));
        end
        tick();
        if (!keep || toggle) req[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0;
        end
        tick(); tick();
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        @(negedge clk);
        chk("rst_ack",   32'(ack[0]),   32'd0);
        chk("rst_ready", 32'(ready[0]), 32'd1);
        chk("rst_rdata", rdata[0],      32'd0);
        chk("rst_err",   32'(err[0]),   32'd0);
        chk("rst_stall", 32'(stall[0]), 32'd0);
        tick();

        // Known contents everywhere so every later read has a defined answer.
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < DEP; i++)
                access(d, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);

        // Write then read back at LATENCY=2.
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

        // LATENCY=1 back-to-back reads with req held across the ack.
        access(1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        access(1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0);

        // Error cases: misaligned write leaves 0x10 intact; out-of-range.
        access(0, 1'b1, 32'h12, 32'h12345678, 1'b0, 1'b0);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        access(0, 1'b0, 32'(4 * DEP), 32'h0, 1'b0, 1'b0);
        access(0, 1'b1, 32'(4 * DEP), 32'h55AA55AA, 1'b0, 1'b0);

        // Last word round-trip.
        access(0, 1'b1, 32'(4 * (DEP - 1)), 32'hA5A5C3C3, 1'b0, 1'b0);
        access(0, 1'b0, 32'(4 * (DEP - 1)), 32'h0, 1'b0, 1'b0);

        // req/addr/we scrambled during WAIT: one ack, captured access wins.
        access(3, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_second_ack", 32'(ack[3]), 32'd0);
            tick();
        end

        // Reset in the middle of a pending write.
        access(3, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0);
        access(3, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
        req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h20; wdata[3] = 32'h0BADF00D;
        tick();
        req[3] = 1'b0;
        tick();
        rst[3] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk("rst_mid_ack", 32'(ack[3]), 32'd0);
        end
        tick();
        rst[3] = 1'b0;
        @(negedge clk);
        chk("rst_mid_ack_after", 32'(ack[3]),   32'd0);
        chk("rst_mid_rdata",     rdata[3],      32'd0);
        chk("rst_mid_err",       32'(err[3]),   32'd0);
        chk("rst_mid_ready",     32'(ready[3]), 32'd1);
        tick();
        access(3, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);

        // Mixed random traffic on LATENCY 1, 3 and 7.
        for (int k = 0; k < 1000; k++) begin
            int          d;
            int          r;
            logic [31:0] a;
            d = 1 + (k % 3);
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 32'($urandom_range(0, DEP - 1) * 4 + $urandom_range(1, 3));
            else if (r == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0400;
            else             a = 32'($urandom_range(0, DEP - 1) * 4);
            access(d, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
